// File: rtl/vtg_pkg.sv
`timescale 1ns/1ps
// Shared types for the video timing generator: FSM states, per-axis timing
// parameter record and the parameter validity check.
package vtg_pkg;

  // Parameter fields are held at this width; CNT_W of the core must not exceed it.
  localparam int PAR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } vtg_state_e;

  typedef struct packed {
    logic [PAR_W-1:0] total;
    logic [PAR_W-1:0] act;
    logic [PAR_W-1:0] sw;
    logic [PAR_W-1:0] bp;
  } axis_par_t;

  // Two guard bits keep sw+bp+act from aliasing back below total.
  function automatic logic axis_valid(input axis_par_t p);
    logic [PAR_W+1:0] sum_v;
    logic             nz_v;
    sum_v = {2'b00, p.sw} + {2'b00, p.bp} + {2'b00, p.act};
    nz_v  = (p.total != {PAR_W{1'b0}}) && (p.act != {PAR_W{1'b0}}) &&
            (p.sw != {PAR_W{1'b0}}) && (p.bp != {PAR_W{1'b0}});
    axis_valid = nz_v && (sum_v <= {2'b00, p.total});
  endfunction

endpackage

// File: rtl/vtg_axis.sv
`timescale 1ns/1ps
// One timing axis decoder: sync, active window and end-of-count for a given
// position under a given parameter set. Purely combinational.
module vtg_axis
  import vtg_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic [CNT_W-1:0] cnt,
  input  axis_par_t        par,
  output logic             sync_s,
  output logic             act_s,
  output logic             end_s
);

  localparam int XW = PAR_W + 2;
  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};

  logic [XW-1:0] cnt_x_s;
  logic [XW-1:0] lo_s;
  logic [XW-1:0] hi_s;
  logic [XW-1:0] last_s;

  assign cnt_x_s = XW'(cnt);
  assign lo_s    = XW'(par.sw) + XW'(par.bp);
  assign hi_s    = lo_s + XW'(par.act);
  assign last_s  = XW'(par.total) - X_ONE;

  assign sync_s = (cnt_x_s < XW'(par.sw));
  assign act_s  = (cnt_x_s >= lo_s) && (cnt_x_s < hi_s);
  assign end_s  = (cnt_x_s == last_s);

endmodule

// File: rtl/vtg_core.sv
`timescale 1ns/1ps
// Video timing generator: shadowed H/V timing, genlock frame restart and
// start/stop on frame boundaries. All outputs come straight from registers.
module vtg_core
  import vtg_pkg::*;
#(
  parameter int CNT_W  = 12,
  parameter int FCNT_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              iEN,
  input  logic [CNT_W-1:0]  iHTOTAL,
  input  logic [CNT_W-1:0]  iHACT,
  input  logic [CNT_W-1:0]  iHS_W,
  input  logic [CNT_W-1:0]  iHBP,
  input  logic [CNT_W-1:0]  iVTOTAL,
  input  logic [CNT_W-1:0]  iVACT,
  input  logic [CNT_W-1:0]  iVS_W,
  input  logic [CNT_W-1:0]  iVBP,
  input  logic              iHS_POL,
  input  logic              iVS_POL,
  input  logic              iLOCK_EN,
  input  logic              iEXT_VS,
  output logic              oHSYNC,
  output logic              oVSYNC,
  output logic              oDE,
  output logic              oFIELD,
  output logic [CNT_W-1:0]  oHCOUNT,
  output logic [CNT_W-1:0]  oVCOUNT,
  output logic              oFRAME_START,
  output logic              oLINE_START,
  output logic [FCNT_W-1:0] oFRAME_CNT,
  output logic              oPARAM_ERR,
  output logic              oLOCKED,
  output logic              oBUSY
);

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};
  localparam axis_par_t         PAR_ZERO = '{total: {PAR_W{1'b0}}, act: {PAR_W{1'b0}},
                                             sw: {PAR_W{1'b0}}, bp: {PAR_W{1'b0}}};

  vtg_state_e        state_r;
  vtg_state_e        nxt_state_s;
  axis_par_t         sh_h_r;
  axis_par_t         sh_v_r;
  axis_par_t         live_h_s;
  axis_par_t         live_v_s;
  axis_par_t         nxt_sh_h_s;
  axis_par_t         nxt_sh_v_s;
  logic [CNT_W-1:0]  h_r;
  logic [CNT_W-1:0]  v_r;
  logic [CNT_W-1:0]  nxt_h_s;
  logic [CNT_W-1:0]  nxt_v_s;
  logic              h_end_r;
  logic              v_end_r;
  logic              field_r;
  logic              nxt_field_s;
  logic [FCNT_W-1:0] fcnt_r;
  logic [FCNT_W-1:0] nxt_fcnt_s;
  logic              perr_r;
  logic              nxt_perr_s;
  logic              locked_r;
  logic              nxt_locked_s;
  logic              hs_act_r;
  logic              vs_act_r;
  logic              de_r;
  logic              fs_r;
  logic              ls_r;
  logic              busy_r;
  logic              load_s;
  logic              live_ok_s;
  logic              nat_wrap_s;
  logic              ext_s;
  logic              wrap_s;
  logic              run_nxt_s;
  logic              h_sync_s;
  logic              h_act_s;
  logic              h_end_s;
  logic              v_sync_s;
  logic              v_act_s;
  logic              v_end_s;

  assign live_h_s = '{total: PAR_W'(iHTOTAL), act: PAR_W'(iHACT),
                      sw: PAR_W'(iHS_W), bp: PAR_W'(iHBP)};
  assign live_v_s = '{total: PAR_W'(iVTOTAL), act: PAR_W'(iVACT),
                      sw: PAR_W'(iVS_W), bp: PAR_W'(iVBP)};
  assign live_ok_s = axis_valid(live_h_s) && axis_valid(live_v_s);

  // End flags are registered alongside the counters, so they describe h_r/v_r.
  assign nat_wrap_s = (state_r != IDLE) && h_end_r && v_end_r;
  assign ext_s      = (state_r == RUN) && iLOCK_EN && iEXT_VS;
  assign wrap_s     = nat_wrap_s || ext_s;

  // Next state, next position and frame-boundary bookkeeping
  always_comb begin
    nxt_state_s = state_r;
    nxt_h_s     = h_r;
    nxt_v_s     = v_r;
    nxt_field_s = field_r;
    nxt_fcnt_s  = fcnt_r;
    nxt_perr_s  = perr_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        nxt_h_s = CNT_ZERO;
        nxt_v_s = CNT_ZERO;
        if (iEN) begin
          if (live_ok_s) begin
            nxt_state_s = RUN;
            load_s      = 1'b1;
            nxt_perr_s  = 1'b0;
          end else begin
            nxt_perr_s  = 1'b1;
          end
        end else begin
          nxt_state_s = IDLE;
        end
      end
      RUN, STOP: begin
        if (wrap_s) begin
          nxt_h_s     = CNT_ZERO;
          nxt_v_s     = CNT_ZERO;
          nxt_field_s = ~field_r;
          nxt_fcnt_s  = fcnt_r + FCNT_ONE;
          if (iEN) begin
            nxt_state_s = RUN;
            load_s      = live_ok_s;
            nxt_perr_s  = ~live_ok_s;
          end else begin
            nxt_state_s = IDLE;
          end
        end else begin
          nxt_state_s = iEN ? RUN : STOP;
          if (h_end_r) begin
            nxt_h_s = CNT_ZERO;
            nxt_v_s = v_r + CNT_ONE;
          end else begin
            nxt_h_s = h_r + CNT_ONE;
          end
        end
      end
      default: begin
        nxt_state_s = IDLE;
        nxt_h_s     = CNT_ZERO;
        nxt_v_s     = CNT_ZERO;
      end
    endcase
  end

  // Lock tracking: a genlock pulse is judged against the natural frame end
  always_comb begin
    nxt_locked_s = locked_r;
    if (!iLOCK_EN) begin
      nxt_locked_s = 1'b0;
    end else if (ext_s) begin
      nxt_locked_s = nat_wrap_s;
    end else begin
      nxt_locked_s = locked_r;
    end
  end

  assign nxt_sh_h_s = load_s ? live_h_s : sh_h_r;
  assign nxt_sh_v_s = load_s ? live_v_s : sh_v_r;
  assign run_nxt_s  = (nxt_state_s != IDLE);

  // Decoders look at the next position so the registered outputs line up with it.
  vtg_axis #(.CNT_W(CNT_W)) u_h_axis (
    .cnt    (nxt_h_s),
    .par    (nxt_sh_h_s),
    .sync_s (h_sync_s),
    .act_s  (h_act_s),
    .end_s  (h_end_s)
  );

  vtg_axis #(.CNT_W(CNT_W)) u_v_axis (
    .cnt    (nxt_v_s),
    .par    (nxt_sh_v_s),
    .sync_s (v_sync_s),
    .act_s  (v_act_s),
    .end_s  (v_end_s)
  );

  // FSM, shadow registers, counters and all registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= IDLE;
      sh_h_r   <= PAR_ZERO;
      sh_v_r   <= PAR_ZERO;
      h_r      <= CNT_ZERO;
      v_r      <= CNT_ZERO;
      h_end_r  <= 1'b0;
      v_end_r  <= 1'b0;
      field_r  <= 1'b0;
      fcnt_r   <= {FCNT_W{1'b0}};
      perr_r   <= 1'b0;
      locked_r <= 1'b0;
      hs_act_r <= 1'b0;
      vs_act_r <= 1'b0;
      de_r     <= 1'b0;
      fs_r     <= 1'b0;
      ls_r     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= nxt_state_s;
      sh_h_r   <= nxt_sh_h_s;
      sh_v_r   <= nxt_sh_v_s;
      h_r      <= nxt_h_s;
      v_r      <= nxt_v_s;
      h_end_r  <= h_end_s;
      v_end_r  <= v_end_s;
      field_r  <= nxt_field_s;
      fcnt_r   <= nxt_fcnt_s;
      perr_r   <= nxt_perr_s;
      locked_r <= nxt_locked_s;
      hs_act_r <= run_nxt_s && h_sync_s;
      vs_act_r <= run_nxt_s && v_sync_s;
      de_r     <= run_nxt_s && h_act_s && v_act_s;
      fs_r     <= run_nxt_s && (nxt_h_s == CNT_ZERO) && (nxt_v_s == CNT_ZERO);
      ls_r     <= run_nxt_s && (nxt_h_s == CNT_ZERO);
      busy_r   <= run_nxt_s;
    end
  end

  // Polarity is a live output inversion, so idle/reset levels follow the POL pins.
  assign oHSYNC       = hs_act_r ^ iHS_POL;
  assign oVSYNC       = vs_act_r ^ iVS_POL;
  assign oDE          = de_r;
  assign oFIELD       = field_r;
  assign oHCOUNT      = h_r;
  assign oVCOUNT      = v_r;
  assign oFRAME_START = fs_r;
  assign oLINE_START  = ls_r;
  assign oFRAME_CNT   = fcnt_r;
  assign oPARAM_ERR   = perr_r;
  assign oLOCKED      = locked_r;
  assign oBUSY        = busy_r;

endmodule

// File: tb/tb_vtg_core.sv
`timescale 1ns/1ps
// Directed bench for vtg_core: a frame-position model checked every cycle,
// plus hand-computed spot checks that pin the model.
module tb_vtg_core;

  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;

  logic              CLK, RST_N, iEN;
  logic [CNT_W-1:0]  iHTOTAL, iHACT, iHS_W, iHBP, iVTOTAL, iVACT, iVS_W, iVBP;
  logic              iHS_POL, iVS_POL, iLOCK_EN, iEXT_VS;
  logic              oHSYNC, oVSYNC, oDE, oFIELD, oFRAME_START, oLINE_START;
  logic              oPARAM_ERR, oLOCKED, oBUSY;
  logic [CNT_W-1:0]  oHCOUNT, oVCOUNT;
  logic [FCNT_W-1:0] oFRAME_CNT;

  vtg_core #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .iEN(iEN),
    .iHTOTAL(iHTOTAL), .iHACT(iHACT), .iHS_W(iHS_W), .iHBP(iHBP),
    .iVTOTAL(iVTOTAL), .iVACT(iVACT), .iVS_W(iVS_W), .iVBP(iVBP),
    .iHS_POL(iHS_POL), .iVS_POL(iVS_POL), .iLOCK_EN(iLOCK_EN), .iEXT_VS(iEXT_VS),
    .oHSYNC(oHSYNC), .oVSYNC(oVSYNC), .oDE(oDE), .oFIELD(oFIELD),
    .oHCOUNT(oHCOUNT), .oVCOUNT(oVCOUNT), .oFRAME_START(oFRAME_START),
    .oLINE_START(oLINE_START), .oFRAME_CNT(oFRAME_CNT), .oPARAM_ERR(oPARAM_ERR),
    .oLOCKED(oLOCKED), .oBUSY(oBUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a linear position inside the frame; h and v are derived from it.
  bit m_busy = 1'b0, m_en = 1'b0, m_field = 1'b0, m_perr = 1'b0, m_locked = 1'b0;
  int m_pos = 0, m_fcnt = 0;
  int m_ht = 1, m_ha = 1, m_hs = 1, m_hb = 1, m_vt = 1, m_va = 1, m_vs = 1, m_vb = 1;

  function automatic bit live_ok();
    bit h_ok, v_ok;
    h_ok = iHTOTAL >= 1 && iHACT >= 1 && iHS_W >= 1 && iHBP >= 1 &&
           (int'(iHS_W) + int'(iHBP) + int'(iHACT) <= int'(iHTOTAL));
    v_ok = iVTOTAL >= 1 && iVACT >= 1 && iVS_W >= 1 && iVBP >= 1 &&
           (int'(iVS_W) + int'(iVBP) + int'(iVACT) <= int'(iVTOTAL));
    return h_ok && v_ok;
  endfunction

  task automatic try_load();
    if (live_ok()) begin
      m_ht = int'(iHTOTAL); m_ha = int'(iHACT); m_hs = int'(iHS_W); m_hb = int'(iHBP);
      m_vt = int'(iVTOTAL); m_va = int'(iVACT); m_vs = int'(iVS_W); m_vb = int'(iVBP);
      m_perr = 1'b0;
    end else begin
      m_perr = 1'b1;
    end
  endtask

  task automatic model_step();
    bit nat, ext;
    if (!RST_N) begin
      m_busy = 1'b0; m_en = 1'b0; m_field = 1'b0; m_perr = 1'b0; m_locked = 1'b0;
      m_pos = 0; m_fcnt = 0;
      return;
    end
    ext = m_busy && m_en && iLOCK_EN && iEXT_VS;
    nat = m_busy && (m_pos == m_ht * m_vt - 1);
    if (!iLOCK_EN) m_locked = 1'b0;
    else if (ext) m_locked = nat;
    if (!m_busy) begin
      if (iEN) begin
        if (live_ok()) begin
          try_load(); m_busy = 1'b1; m_pos = 0; m_en = 1'b1;
        end else begin
          m_perr = 1'b1;
        end
      end
    end else if (nat || ext) begin
      m_field = !m_field;
      m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
      m_pos = 0;
      if (iEN) try_load();
      else m_busy = 1'b0;
      m_en = iEN;
    end else begin
      m_pos++;
      m_en = iEN;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge RST_N);
      model_step();
    end
  end

  // Compare process: every output against the model on every falling edge.
  task automatic compare_all();
    int h, v;
    bit hs, vs, de, fs, ls;
    h = 0; v = 0;
    if (m_busy) begin
      h = m_pos % m_ht;
      v = m_pos / m_ht;
    end
    hs = m_busy && (h < m_hs);
    vs = m_busy && (v < m_vs);
    de = m_busy && (h >= m_hs + m_hb) && (h < m_hs + m_hb + m_ha) &&
         (v >= m_vs + m_vb) && (v < m_vs + m_vb + m_va);
    fs = m_busy && (m_pos == 0);
    ls = m_busy && (h == 0);
    chk("m_hcount", oHCOUNT, h);
    chk("m_vcount", oVCOUNT, v);
    chk("m_hsync", oHSYNC, hs ^ iHS_POL);
    chk("m_vsync", oVSYNC, vs ^ iVS_POL);
    chk("m_de", oDE, de);
    chk("m_fs", oFRAME_START, fs);
    chk("m_ls", oLINE_START, ls);
    chk("m_field", oFIELD, m_field);
    chk("m_fcnt", oFRAME_CNT, m_fcnt);
    chk("m_perr", oPARAM_ERR, m_perr);
    chk("m_locked", oLOCKED, m_locked);
    chk("m_busy", oBUSY, m_busy);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      compare_all();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic count_frame(input int n, output int de_n, output int hs_n, output int fs_n);
    de_n = 0; hs_n = 0; fs_n = 0;
    for (int k = 0; k < n; k++) begin
      de_n += int'(oDE);
      hs_n += int'(oHSYNC);
      fs_n += int'(oFRAME_START);
      cyc(1);
    end
  endtask

  int de_n, hs_n, fs_n;
  logic f0;
  int c0;

  initial begin
    RST_N = 1'b0; iEN = 1'b0;
    iHTOTAL = 12'd10; iHACT = 12'd4; iHS_W = 12'd2; iHBP = 12'd2;
    iVTOTAL = 12'd6;  iVACT = 12'd3; iVS_W = 12'd1; iVBP = 12'd1;
    iHS_POL = 1'b0; iVS_POL = 1'b0; iLOCK_EN = 1'b0; iEXT_VS = 1'b0;
    cyc(3);
    chk("rst_hcount", oHCOUNT, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_hsync", oHSYNC, 0);
    chk("rst_de", oDE, 0);
    RST_N = 1'b1;
    cyc(2);
    chk("idle_busy", oBUSY, 0);

    // invalid parameters at start: stays idle with error
    iHACT = 12'd7; iEN = 1'b1;
    cyc(1);
    chk("bad_start_err", oPARAM_ERR, 1);
    chk("bad_start_busy", oBUSY, 0);
    iHACT = 12'd4;
    cyc(1);
    chk("start_busy", oBUSY, 1);
    chk("start_h", oHCOUNT, 0);
    chk("start_v", oVCOUNT, 0);
    chk("start_fs", oFRAME_START, 1);
    chk("start_hsync", oHSYNC, 1);
    chk("start_vsync", oVSYNC, 1);
    chk("start_err", oPARAM_ERR, 0);

    // test 1: 60-cycle frame, 12 DE, 12 HSYNC, one FRAME_START
    count_frame(60, de_n, hs_n, fs_n);
    chk("t1_de_cnt", de_n, 12);
    chk("t1_hs_cnt", hs_n, 12);
    chk("t1_fs_cnt", fs_n, 1);
    chk("t1_fs_again", oFRAME_START, 1);
    chk("t1_fcnt", oFRAME_CNT, 1);
    chk("t1_field", oFIELD, 1);

    // test 2: HACT change mid-frame applies at the next frame
    cyc(5);
    iHACT = 12'd5;
    count_frame(55, de_n, hs_n, fs_n);
    chk("t2_de_old", de_n, 12);
    count_frame(60, de_n, hs_n, fs_n);
    chk("t2_de_new", de_n, 15);
    chk("t2_err", oPARAM_ERR, 0);

    // test 3: invalid load at wrap keeps old timing, recovery clears error
    iHACT = 12'd7;
    count_frame(60, de_n, hs_n, fs_n);
    chk("t3_err_set", oPARAM_ERR, 1);
    iHACT = 12'd4;
    count_frame(60, de_n, hs_n, fs_n);
    chk("t3_de_kept", de_n, 15);
    chk("t3_err_clr", oPARAM_ERR, 0);
    count_frame(60, de_n, hs_n, fs_n);
    chk("t3_de_back", de_n, 12);

    // test 4: aligned genlock pulses lock, a misaligned one restarts and unlocks
    iLOCK_EN = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cyc(59);
      iEXT_VS = 1'b1;
      cyc(1);
      iEXT_VS = 1'b0;
      chk("t4_locked", oLOCKED, 1);
      chk("t4_aligned_h", oHCOUNT, 0);
    end
    cyc(23);
    chk("t4_pos_h", oHCOUNT, 3);
    chk("t4_pos_v", oVCOUNT, 2);
    f0 = oFIELD;
    c0 = int'(oFRAME_CNT);
    iEXT_VS = 1'b1;
    cyc(1);
    iEXT_VS = 1'b0;
    chk("t4_jump_h", oHCOUNT, 0);
    chk("t4_jump_v", oVCOUNT, 0);
    chk("t4_field", oFIELD, !f0);
    chk("t4_fcnt", oFRAME_CNT, c0 + 1);
    chk("t4_unlocked", oLOCKED, 0);
    chk("t4_fs", oFRAME_START, 1);
    iLOCK_EN = 1'b0;

    // test 5: stop completes the frame; re-raise before wrap gives no gap
    cyc(10);
    iEN = 1'b0;
    cyc(49);
    chk("t5_busy_end", oBUSY, 1);
    chk("t5_h_end", oHCOUNT, 9);
    chk("t5_v_end", oVCOUNT, 5);
    cyc(1);
    chk("t5_idle_busy", oBUSY, 0);
    chk("t5_idle_h", oHCOUNT, 0);
    chk("t5_idle_de", oDE, 0);
    chk("t5_idle_fs", oFRAME_START, 0);
    cyc(3);
    iEN = 1'b1;
    cyc(1);
    chk("t5_restart_fs", oFRAME_START, 1);
    cyc(15);
    iEN = 1'b0;
    cyc(10);
    iEN = 1'b1;
    cyc(34);
    chk("t5_h_last", oHCOUNT, 9);
    cyc(1);
    chk("t5_nogap_busy", oBUSY, 1);
    chk("t5_nogap_h", oHCOUNT, 0);
    chk("t5_nogap_fs", oFRAME_START, 1);

    // test 6: asynchronous reset mid-frame
    cyc(30);
    chk("t6_v", oVCOUNT, 3);
    iHS_POL = 1'b1;
    RST_N = 1'b0;
    #1;
    chk("t6_hsync", oHSYNC, 1);
    chk("t6_de", oDE, 0);
    chk("t6_fcnt", oFRAME_CNT, 0);
    chk("t6_busy", oBUSY, 0);
    chk("t6_h", oHCOUNT, 0);
    cyc(2);
    RST_N = 1'b1;
    cyc(1);
    chk("t6_restart_fs", oFRAME_START, 1);
    chk("t6_restart_hsync", oHSYNC, 0);
    cyc(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
